// File: rtl/crc8_frame_check.sv
// CRC-8/EBU receive checker: shifts each accepted byte through the CRC LSB first,
// forwards payload one byte behind (so the CRC byte is stripped) and reports per frame.
module crc8_frame_check #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [7:0]       axiid,
    input  logic             axiil,
    output logic             axiir,
    output logic             axiov,
    output logic [7:0]       axiod,
    output logic             axiol,
    output logic             crc_valid,
    output logic             crc_ok,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] bad_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [7:0] CRC_INIT = 8'hFF;
    localparam logic [7:0] POLY_REF = 8'hB8;

    state_t           state_q, state_d;
    logic [7:0]       crc_q, crc_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             last_q, last_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             axiov_q, axiov_d;
    logic [7:0]       axiod_q, axiod_d;
    logic             axiol_q, axiol_d;
    logic             crc_valid_q, crc_valid_d;
    logic             crc_ok_q, crc_ok_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;

    logic             fb;
    logic [7:0]       crc_step;

    assign fb       = crc_q[0] ^ shift_q[0];
    assign crc_step = {1'b0, crc_q[7:1]} ^ (fb ? POLY_REF : 8'h00);

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        last_d       = last_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        axiov_d      = 1'b0;
        axiod_d      = axiod_q;
        axiol_d      = 1'b0;
        crc_valid_d  = 1'b0;
        crc_ok_d     = crc_ok_q;
        good_d       = good_q;
        bad_d        = bad_q;

        case (state_q)
            IDLE: begin
                if (axiiv) begin
                    shift_d    = axiid;
                    last_d     = axiil;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = (byte_cnt_q == 2'd2) ? 2'd2 : byte_cnt_q + 2'd1;
                    // A new payload byte pushes the previous one out; the CRC byte never enters hold.
                    if (!axiil) begin
                        if (hold_valid_q) begin
                            axiov_d = 1'b1;
                            axiod_d = hold_q;
                        end
                        hold_d       = axiid;
                        hold_valid_d = 1'b1;
                    end
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                crc_d     = crc_step;
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (last_q) begin
                        // Result and final payload byte are registered so they land in the REPORT cycle.
                        state_d     = REPORT;
                        crc_valid_d = 1'b1;
                        crc_ok_d    = (crc_step == 8'h00) && (byte_cnt_q == 2'd2);
                        if (hold_valid_q) begin
                            axiov_d = 1'b1;
                            axiol_d = 1'b1;
                            axiod_d = hold_q;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REPORT: begin
                if (crc_ok_q) begin
                    if (good_q != {CNT_W{1'b1}}) good_d = good_q + CNT_W'(1);
                end else begin
                    if (bad_q != {CNT_W{1'b1}}) bad_d = bad_q + CNT_W'(1);
                end
                crc_d        = CRC_INIT;
                hold_valid_d = 1'b0;
                byte_cnt_d   = 2'd0;
                last_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            crc_q        <= CRC_INIT;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 2'd0;
            last_q       <= 1'b0;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            axiov_q      <= 1'b0;
            axiod_q      <= 8'h00;
            axiol_q      <= 1'b0;
            crc_valid_q  <= 1'b0;
            crc_ok_q     <= 1'b0;
            good_q       <= '0;
            bad_q        <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            axiol_q      <= axiol_d;
            crc_valid_q  <= crc_valid_d;
            crc_ok_q     <= crc_ok_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
        end
    end

    assign axiir      = (state_q == IDLE);
    assign axiov      = axiov_q;
    assign axiod      = axiod_q;
    assign axiol      = axiol_q;
    assign crc_valid  = crc_valid_q;
    assign crc_ok     = crc_ok_q;
    assign good_count = good_q;
    assign bad_count  = bad_q;

endmodule

// File: tb/tb_crc8_frame_check.sv
// Bench for crc8_frame_check: directed and random frames checked against a bytewise
// CRC-8/EBU reference model and a frame-level payload/counter model.
module tb_crc8_frame_check;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             axiiv;
    logic [7:0]       axiid;
    logic             axiil;
    logic             axiir;
    logic             axiov;
    logic [7:0]       axiod;
    logic             axiol;
    logic             crc_valid;
    logic             crc_ok;
    logic [CNT_W-1:0] good_count;
    logic [CNT_W-1:0] bad_count;

    crc8_frame_check #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .axiiv(axiiv), .axiid(axiid), .axiil(axiil), .axiir(axiir),
        .axiov(axiov), .axiod(axiod), .axiol(axiol),
        .crc_valid(crc_valid), .crc_ok(crc_ok),
        .good_count(good_count), .bad_count(bad_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int good_m = 0;
    int bad_m = 0;

    logic [7:0] mon_pay[$];
    logic       mon_last[$];
    int         n_res = 0;
    logic       res_ok;
    logic       res_with_last;
    int         n_acc = 0;
    int         n_stall = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (axiov) begin
                mon_pay.push_back(axiod);
                mon_last.push_back(axiol);
            end
            if (crc_valid) begin
                n_res++;
                res_ok        = crc_ok;
                res_with_last = axiov && axiol;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && axiiv) begin
            if (axiir) n_acc++;
            else       n_stall++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8_ref(input logic [7:0] data[$]);
        logic [7:0] c;
        c = 8'hFF;
        foreach (data[i]) begin
            c = c ^ data[i];
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 8'hB8) : (c >> 1);
        end
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l, input bit keep);
        int n;
        @(negedge clk);
        axiiv = 1'b1;
        axiid = d;
        axiil = l;
        n = 0;
        while (!axiir && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) axiiv = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] pl[$], input logic [7:0] crcb, input bit keep);
        logic [7:0] all[$];
        int  res0;
        int  n;
        bit  exp_ok;
        all = pl;
        all.push_back(crcb);
        exp_ok = (crc8_ref(all) == 8'h00) && (all.size() >= 2);
        mon_pay.delete();
        mon_last.delete();
        n_acc = 0;
        n_stall = 0;
        res0 = n_res;
        foreach (all[i]) send_byte(all[i], (i == all.size() - 1), keep && (i != all.size() - 1));
        n = 0;
        while (n_res == res0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":result_seen"}, n_res - res0, 1);
        @(negedge clk);
        @(negedge clk);
        if (exp_ok) good_m = (good_m < CMAX) ? good_m + 1 : CMAX;
        else        bad_m  = (bad_m  < CMAX) ? bad_m  + 1 : CMAX;
        chk({tag, ":crc_ok"}, res_ok, exp_ok);
        chk({tag, ":accepted"}, n_acc, all.size());
        chk({tag, ":pay_count"}, mon_pay.size(), pl.size());
        if (mon_pay.size() == pl.size())
            foreach (pl[i]) begin
                chk({tag, ":pay_byte"}, mon_pay[i], pl[i]);
                chk({tag, ":pay_last"}, mon_last[i], (i == pl.size() - 1));
            end
        chk({tag, ":last_with_result"}, res_with_last, (pl.size() != 0));
        chk({tag, ":good_count"}, good_count, good_m);
        chk({tag, ":bad_count"}, bad_count, bad_m);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ":axiir"}, axiir, 1);
        chk({tag, ":axiov"}, axiov, 0);
        chk({tag, ":axiod"}, axiod, 0);
        chk({tag, ":axiol"}, axiol, 0);
        chk({tag, ":crc_valid"}, crc_valid, 0);
        chk({tag, ":crc_ok"}, crc_ok, 0);
        chk({tag, ":good"}, good_count, 0);
        chk({tag, ":bad"}, bad_count, 0);
    endtask

    logic [7:0] p_ascii[$];
    logic [7:0] p_rand[$];
    logic [7:0] p_none[$];
    logic [7:0] c_rand;
    int         len;

    initial begin
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 8'h00;
        axiil = 1'b0;
        for (int i = 0; i < 9; i++) p_ascii.push_back(8'h31 + 8'(i));
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_frame("good_frame", p_ascii, 8'h97, 1'b0);
        run_frame("bad_frame", p_ascii, 8'h96, 1'b0);

        run_frame("held_valid", p_ascii, 8'h97, 1'b1);
        chk("held_valid:stall_cycles", n_stall, 72);

        run_frame("single_byte", p_none, 8'hFF, 1'b0);

        run_frame("b2b_good", p_ascii, 8'h97, 1'b1);
        run_frame("b2b_bad", p_ascii, 8'h96, 1'b1);

        for (int f = 0; f < 6; f++) begin
            p_rand.delete();
            len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) p_rand.push_back(8'($urandom));
            c_rand = crc8_ref(p_rand);
            if ($urandom_range(0, 1) == 1) c_rand = c_rand ^ 8'($urandom_range(1, 255));
            run_frame("random", p_rand, c_rand, ($urandom_range(0, 1) == 1));
        end

        for (int i = 0; i < 4; i++) send_byte(p_ascii[i], 1'b0, 1'b0);
        send_byte(p_ascii[4], 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_frame_reset");
        good_m = 0;
        bad_m  = 0;
        @(negedge clk);
        rst = 1'b0;
        run_frame("after_reset", p_ascii, 8'h97, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        good_m = 0;
        bad_m  = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < CMAX; i++) run_frame("sat_fill", p_none, 8'($urandom), 1'b0);
        chk("sat_full", bad_count, CMAX);
        run_frame("sat_hold", p_none, 8'h00, 1'b0);
        chk("sat_stays", bad_count, CMAX);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
